histo_frame_ctrl: RTL

//  Sequencer for the 16-bin run-length histogram datapath. Per frame: pulses hist_init, gates exactly FRAME_LEN

---
 rtl/histo_frame_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/histo_frame_ctrl.sv
// Frame sequencer for the 16-bin run-length histogram: clear, gated capture of one
// frame of bits, drain, valid/ready sweep of all bins, and an idle-time host read port.
module histo_frame_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int NUM_BINS  = 16,
    parameter int CNT_W     = 10,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             src_valid_i,
    input  logic             src_bit_i,
    output logic             src_ready_o,
    output logic             hist_init_o,
    output logic             data_valid_o,
    output logic             data_in_o,
    output logic [3:0]       hist_addr_o,
    input  logic [CNT_W-1:0] hist_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [3:0]       rd_bin_o,
    output logic [CNT_W-1:0] rd_count_o,
    output logic             rd_last_o,
    input  logic             host_req_i,
    input  logic [3:0]       host_addr_i,
    output logic             host_ack_o,
    output logic [CNT_W-1:0] host_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             frame_err_o
);

    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam int DW = $clog2(DRAIN_CYC + 2);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_RD_ADDR = 3'd4;
    localparam logic [2:0] ST_RD_CAPT = 3'd5;
    localparam logic [2:0] ST_RD_HOLD = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [3:0]       bin_q, bin_d;
    logic             src_ready_q, src_ready_d;
    logic             hist_init_q, hist_init_d;
    logic             data_valid_q, data_valid_d;
    logic             data_in_q, data_in_d;
    logic [3:0]       hist_addr_q, hist_addr_d;
    logic             rd_valid_q, rd_valid_d;
    logic [3:0]       rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             rd_last_q, rd_last_d;
    logic             host_p1_q, host_p1_d;
    logic             host_ack_q, host_ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;

    // Next-state and output-register logic for the frame sequencer and host port.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        bin_d        = bin_q;
        src_ready_d  = src_ready_q;
        hist_init_d  = 1'b0;
        data_valid_d = 1'b0;
        data_in_d    = data_in_q;
        hist_addr_d  = hist_addr_q;
        rd_valid_d   = rd_valid_q;
        rd_bin_d     = rd_bin_q;
        rd_count_d   = rd_count_q;
        rd_last_d    = rd_last_q;
        host_p1_d    = 1'b0;
        host_ack_d   = 1'b0;
        done_d       = 1'b0;
        frame_err_d  = frame_err_q;
        case (state_q)
            ST_IDLE: begin
                // A host read owns the address port until its ack; start is dropped meanwhile.
                if (host_p1_q) begin
                    host_ack_d = 1'b1;
                end else if (host_req_i && !host_ack_q) begin
                    hist_addr_d = host_addr_i;
                    host_p1_d   = 1'b1;
                end else if (start_i && !host_ack_q && !host_req_i) begin
                    state_d     = ST_INIT;
                    hist_init_d = 1'b1;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_d     = ST_CAPTURE;
                src_ready_d = 1'b1;
            end
            ST_CAPTURE: begin
                if (src_valid_i && src_ready_q) begin
                    data_valid_d = 1'b1;
                    data_in_d    = src_bit_i;
                    cnt_d        = cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAME_LEN - 1)) begin
                        state_d     = ST_DRAIN;
                        src_ready_d = 1'b0;
                        drain_d     = '0;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // First drain cycle still carries the final data_valid beat.
                if (drain_q == DW'(DRAIN_CYC)) begin
                    state_d     = ST_RD_ADDR;
                    bin_d       = 4'd0;
                    hist_addr_d = 4'd0;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                state_d    = ST_RD_HOLD;
                rd_count_d = hist_data_i;
                rd_bin_d   = bin_q;
                rd_valid_d = 1'b1;
                rd_last_d  = (bin_q == 4'(NUM_BINS - 1));
            end
            ST_RD_HOLD: begin
                if (rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (bin_q == 4'(NUM_BINS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_RD_ADDR;
                        bin_d       = bin_q + 4'd1;
                        hist_addr_d = bin_q + 4'd1;
                    end
                end else begin
                    state_d = ST_RD_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                src_ready_d = 1'b0;
                rd_valid_d  = 1'b0;
                rd_last_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            drain_q      <= '0;
            bin_q        <= 4'd0;
            src_ready_q  <= 1'b0;
            hist_init_q  <= 1'b0;
            data_valid_q <= 1'b0;
            data_in_q    <= 1'b0;
            hist_addr_q  <= 4'd0;
            rd_valid_q   <= 1'b0;
            rd_bin_q     <= 4'd0;
            rd_count_q   <= '0;
            rd_last_q    <= 1'b0;
            host_p1_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            bin_q        <= bin_d;
            src_ready_q  <= src_ready_d;
            hist_init_q  <= hist_init_d;
            data_valid_q <= data_valid_d;
            data_in_q    <= data_in_d;
            hist_addr_q  <= hist_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_bin_q     <= rd_bin_d;
            rd_count_q   <= rd_count_d;
            rd_last_q    <= rd_last_d;
            host_p1_q    <= host_p1_d;
            host_ack_q   <= host_ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign src_ready_o  = src_ready_q;
    assign hist_init_o  = hist_init_q;
    assign data_valid_o = data_valid_q;
    assign data_in_o    = data_in_q;
    assign hist_addr_o  = hist_addr_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_bin_o     = rd_bin_q;
    assign rd_count_o   = rd_count_q;
    assign rd_last_o    = rd_last_q;
    assign host_ack_o   = host_ack_q;
    // Bin value arrives from the histogram in the ack cycle itself, so it is gated rather than re-registered.
    assign host_data_o  = host_ack_q ? hist_data_i : '0;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign frame_err_o  = frame_err_q;

endmodule
